// File: rtl/jb_fft_seq_if.sv
`default_nettype none
// ============================================================================
// jb_fft_seq_if : sample-in / FFT-out stream bundle for jb_fft_seq
// Rev 1.0
// ============================================================================
interface jb_fft_seq_if;
  logic       s_valid;
  logic       s_ready;
  logic       fft_ready;
  logic       fft_valid;
  logic       fft_sof;
  logic       fft_eof;
  logic [8:0] fft_idx;

  modport master (
    output s_valid, fft_ready,
    input  s_ready, fft_valid, fft_sof, fft_eof, fft_idx
  );

  modport slave (
    input  s_valid, fft_ready,
    output s_ready, fft_valid, fft_sof, fft_eof, fft_idx
  );
endinterface
`default_nettype wire

// File: rtl/jb_fft_seq.sv
`default_nettype none
// ============================================================================
// jb_fft_seq : PRACH FFT input sequencer (CP skip, N-sample gating, symbols)
// Optional stall statistics port enabled by JB_FFT_SEQ_STATS_EN. Rev 1.0
// ============================================================================
module jb_fft_seq #(
  parameter int CP_W  = 10,
  parameter int SYM_W = 4
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             clk_en,
  input  wire logic             start,
  input  wire logic             abort,
  input  wire logic [1:0]       cfg_fft_log2,
  input  wire logic [CP_W-1:0]  cfg_cp_len,
  input  wire logic [SYM_W-1:0] cfg_num_sym,
  jb_fft_seq_if.slave           strm,
  output logic [SYM_W-1:0]      sym_idx,
  output logic                  busy,
  output logic                  done,
`ifdef JB_FFT_SEQ_STATS_EN
  output logic [15:0]           stall_cnt,
`endif
  output logic                  cfg_err
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CP   = 3'd1,
    ST_WAIT = 3'd2,
    ST_FFT  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t           state;
  logic [CP_W-1:0]  cp_cnt;
  logic [8:0]       cnt;
  logic [CP_W-1:0]  cp_len_q;
  logic [SYM_W-1:0] num_sym_q;
  logic [1:0]       log2_q;
  logic [8:0]       last_idx;
  logic             beat;
  logic             cfg_bad;
  logic             start_ok;

  always_comb begin
    last_idx = 9'd511;
    case (log2_q)
      2'd0:    last_idx = 9'd127;
      2'd1:    last_idx = 9'd255;
      default: last_idx = 9'd511;
    endcase
  end

  assign cfg_bad  = (cfg_num_sym == '0) || (cfg_fft_log2 == 2'd3);
  assign start_ok = (state == ST_IDLE) && start && clk_en && !cfg_bad;

  // Ready is combinational in FFT so a sample goes to the core in the cycle it is accepted.
  assign strm.s_ready   = (state == ST_CP) || ((state == ST_FFT) && strm.fft_ready);
  assign beat           = strm.s_valid && strm.s_ready && clk_en;
  assign strm.fft_valid = (state == ST_FFT) && beat;
  assign strm.fft_sof   = strm.fft_valid && (cnt == 9'd0);
  assign strm.fft_eof   = strm.fft_valid && (cnt == last_idx);
  assign strm.fft_idx   = cnt;
  assign busy           = (state != ST_IDLE);
  assign done           = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (reset || abort) begin
      state     <= ST_IDLE;
      cp_cnt    <= '0;
      cnt       <= '0;
      sym_idx   <= '0;
      cp_len_q  <= '0;
      num_sym_q <= '0;
      log2_q    <= '0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      if (clk_en) begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              if (cfg_bad) begin
                cfg_err <= 1'b1;
              end else begin
                cp_len_q  <= cfg_cp_len;
                num_sym_q <= cfg_num_sym;
                log2_q    <= cfg_fft_log2;
                sym_idx   <= '0;
                cnt       <= '0;
                cp_cnt    <= '0;
                state     <= (cfg_cp_len != '0) ? ST_CP : ST_WAIT;
              end
            end
          end
          ST_CP: begin
            if (beat) begin
              if (cp_cnt == cp_len_q - CP_W'(1)) begin
                cp_cnt <= '0;
                state  <= ST_WAIT;
              end else begin
                cp_cnt <= cp_cnt + CP_W'(1);
              end
            end
          end
          ST_WAIT: begin
            if (strm.fft_ready) state <= ST_FFT;
          end
          ST_FFT: begin
            if (beat) begin
              if (cnt == last_idx) begin
                cnt <= '0;
                if (sym_idx == num_sym_q - SYM_W'(1)) begin
                  state <= ST_DONE;
                end else begin
                  sym_idx <= sym_idx + SYM_W'(1);
                  state   <= (cp_len_q != '0) ? ST_CP : ST_WAIT;
                end
              end else begin
                cnt <= cnt + 9'd1;
              end
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef JB_FFT_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (reset || abort) begin
      stall_cnt <= '0;
    end else if (start_ok) begin
      stall_cnt <= '0;
    end else if (clk_en && (state == ST_FFT) && strm.s_valid && !strm.fft_ready &&
                 (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_jb_fft_seq.sv
`default_nettype none
// ============================================================================
// tb_jb_fft_seq : directed self-checking bench for jb_fft_seq
// Rev 1.0
// ============================================================================
module tb_jb_fft_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       clk_en;
  logic       start;
  logic       abort;
  logic [1:0] cfg_fft_log2;
  logic [9:0] cfg_cp_len;
  logic [3:0] cfg_num_sym;
  logic [3:0] sym_idx;
  logic       busy;
  logic       done;
  logic       cfg_err;
`ifdef JB_FFT_SEQ_STATS_EN
  logic [15:0] stall_cnt;
`endif

  jb_fft_seq_if sif ();

  jb_fft_seq #(.CP_W(10), .SYM_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .clk_en       (clk_en),
    .start        (start),
    .abort        (abort),
    .cfg_fft_log2 (cfg_fft_log2),
    .cfg_cp_len   (cfg_cp_len),
    .cfg_num_sym  (cfg_num_sym),
    .strm         (sif),
    .sym_idx      (sym_idx),
    .busy         (busy),
    .done         (done),
`ifdef JB_FFT_SEQ_STATS_EN
    .stall_cnt    (stall_cnt),
`endif
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  int beats, fv, sofs, eofs, done_cnt, busy_cyc;
  int idx_err, sof_err, eof_err, sym_err, vld_err, stall_err, done_err;
  int exp_idx, exp_sym, cur_n, stall_at_cur;
  bit stalling, prev_done, prev_eof, ended, aborted;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    beats = 0; fv = 0; sofs = 0; eofs = 0; done_cnt = 0; busy_cyc = 0;
    idx_err = 0; sof_err = 0; eof_err = 0; sym_err = 0; vld_err = 0;
    stall_err = 0; done_err = 0; exp_idx = 0; exp_sym = 0;
    stalling = 1'b0; prev_done = 1'b0; prev_eof = 1'b0; ended = 1'b0; aborted = 1'b0;
  endtask

  // Observes the current cycle against the expected stream and tallies events.
  task automatic sample();
    bit bt;
    bt = sif.s_valid && sif.s_ready && clk_en;
    if (bt) beats++;
    if (sif.fft_valid) begin
      fv++;
      if (!bt) vld_err++;
      if (int'(sif.fft_idx) != exp_idx) idx_err++;
      if (sif.fft_sof != (exp_idx == 0)) sof_err++;
      if (sif.fft_eof != (exp_idx == cur_n - 1)) eof_err++;
      if (int'(sym_idx) != exp_sym) sym_err++;
      if (sif.fft_sof) sofs++;
      if (sif.fft_eof) eofs++;
      if (exp_idx == cur_n - 1) begin
        exp_idx = 0;
        exp_sym++;
      end else begin
        exp_idx++;
      end
    end else if (sif.fft_sof || sif.fft_eof) begin
      sof_err++;
    end
    if (stalling && (sif.s_ready || int'(sif.fft_idx) != stall_at_cur)) stall_err++;
    if (done && !prev_done) begin
      done_cnt++;
      if (!prev_eof) done_err++;
    end
    if (busy) busy_cyc++;
    prev_done = done;
    prev_eof  = sif.fft_valid && sif.fft_eof;
  endtask

  task automatic tick();
    #2;
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int lg, input int cp, input int ns, input int stall_at,
                     input bit ce_tog, input int abort_sym, input int abort_idx,
                     input int budget);
    int stall_left;
    clear_stats();
    cur_n        = 128 << lg;
    stall_at_cur = stall_at;
    stall_left   = -1;
    cfg_fft_log2 = 2'(lg);
    cfg_cp_len   = 10'(cp);
    cfg_num_sym  = 4'(ns);
    clk_en       = 1'b1;
    sif.s_valid  = 1'b1;
    sif.fft_ready = 1'b1;
    start        = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < budget && !ended; c++) begin
      clk_en        = ce_tog ? (c % 2 == 1) : 1'b1;
      sif.fft_ready = 1'b1;
      stalling      = 1'b0;
      if (stall_at >= 0 && busy && int'(sif.fft_idx) == stall_at && stall_left < 0)
        stall_left = 5;
      if (stall_left > 0) begin
        sif.fft_ready = 1'b0;
        stalling      = 1'b1;
        stall_left--;
      end
      if (abort_sym >= 0 && busy && int'(sym_idx) == abort_sym &&
          int'(sif.fft_idx) == abort_idx) begin
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("abort_outputs_zero",
              32'({sif.s_ready, sif.fft_valid, sif.fft_sof, sif.fft_eof, sif.fft_idx,
                   sym_idx, busy, done, cfg_err}), 32'd0);
        tick();
        check("abort_start_ignored", 32'(busy), 32'd0);
        aborted = 1'b1;
        ended   = 1'b1;
      end else begin
        tick();
        if (done_cnt > 0) ended = 1'b1;
      end
    end
    stalling = 1'b0;
    clk_en   = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1; clk_en = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_fft_log2 = 2'd0; cfg_cp_len = '0; cfg_num_sym = '0;
    sif.s_valid = 1'b0; sif.fft_ready = 1'b0;
    clear_stats();
    cur_n = 128; stall_at_cur = -1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_outputs_zero",
          32'({sif.s_ready, sif.fft_valid, sif.fft_sof, sif.fft_eof, sif.fft_idx,
               sym_idx, busy, done, cfg_err}), 32'd0);

    // 128-point, 32 CP samples, 2 symbols
    run(0, 32, 2, -1, 1'b0, -1, -1, 3000);
    check("t1_done_pulses", 32'(done_cnt), 32'd1);
    check("t1_beats", 32'(beats), 32'd320);
    check("t1_fft_valid", 32'(fv), 32'd256);
    check("t1_sof_eof", 32'({sofs[15:0], eofs[15:0]}), 32'h0002_0002);
    check("t1_stream_errs", 32'(idx_err + sof_err + eof_err + sym_err + vld_err), 32'd0);
    check("t1_done_after_eof", 32'(done_err), 32'd0);
    check("t1_busy_cycles", 32'(busy_cyc), 32'd323);

    // 512-point, no CP, single symbol
    run(2, 0, 1, -1, 1'b0, -1, -1, 3000);
    check("t2_done_pulses", 32'(done_cnt), 32'd1);
    check("t2_beats", 32'(beats), 32'd512);
    check("t2_fft_valid", 32'(fv), 32'd512);
    check("t2_sof_eof", 32'({sofs[15:0], eofs[15:0]}), 32'h0001_0001);
    check("t2_stream_errs", 32'(idx_err + sof_err + eof_err + sym_err + vld_err + done_err), 32'd0);
    check("t2_busy_cycles", 32'(busy_cyc), 32'd514);

    // fft_ready dropped for 5 cycles at index 100
    run(0, 4, 1, 100, 1'b0, -1, -1, 3000);
    check("t3_done_pulses", 32'(done_cnt), 32'd1);
    check("t3_fft_valid", 32'(fv), 32'd128);
    check("t3_stall_hold_errs", 32'(stall_err), 32'd0);
    check("t3_stream_errs", 32'(idx_err + sof_err + eof_err + vld_err), 32'd0);
`ifdef JB_FFT_SEQ_STATS_EN
    check("t3_stall_cnt", 32'(stall_cnt), 32'd5);
`endif

    // illegal configurations are rejected with a single cfg_err pulse
    cfg_fft_log2 = 2'd0; cfg_cp_len = 10'd8; cfg_num_sym = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_symzero_cfg_err", 32'({cfg_err, busy}), 32'b10);
    tick();
    check("t4_cfg_err_pulse", 32'({cfg_err, busy}), 32'b00);
    cfg_fft_log2 = 2'd3; cfg_num_sym = 4'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_log2_3_cfg_err", 32'({cfg_err, busy}), 32'b10);
    tick();
    check("t4_log2_3_idle", 32'({cfg_err, busy}), 32'b00);

    // abort mid-occasion then a clean restart
    run(0, 8, 2, -1, 1'b0, 1, 60, 3000);
    check("t5_aborted", 32'(aborted), 32'd1);
    check("t5_no_done", 32'(done_cnt), 32'd0);
    run(0, 8, 1, -1, 1'b0, -1, -1, 3000);
    check("t5_restart_done", 32'(done_cnt), 32'd1);
    check("t5_restart_fv", 32'(fv), 32'd128);
    check("t5_restart_errs", 32'(idx_err + sof_err + eof_err + sym_err + vld_err), 32'd0);

    // clk_en toggling every cycle
    run(1, 16, 3, -1, 1'b1, -1, -1, 4000);
    check("t6_done_pulses", 32'(done_cnt), 32'd1);
    check("t6_beats", 32'(beats), 32'd816);
    check("t6_fft_valid", 32'(fv), 32'd768);
    check("t6_sof_eof", 32'({sofs[15:0], eofs[15:0]}), 32'h0003_0003);
    check("t6_stream_errs", 32'(idx_err + sof_err + eof_err + sym_err + vld_err + done_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
